// File: rtl/lcd_ram_reader.sv
// Reads CGRAM/DDRAM bytes back from an HD44780-compatible LCD over the 8-bit TLCD bus:
// busy-flag poll, address write, busy-flag poll, then LEN auto-incrementing data reads.
module lcd_ram_reader #(
    parameter int E_HIGH_CYCLES = 2,
    parameter int E_LOW_CYCLES  = 2,
    parameter int BUSY_TIMEOUT  = 255
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       START,
    input  logic       SEL_CGRAM,
    input  logic [6:0] ADDR,
    input  logic [5:0] LEN,
    output logic       TLCD_E,
    output logic       TLCD_RS,
    output logic       TLCD_RW,
    output logic [7:0] TLCD_DATA_OUT,
    output logic       TLCD_DATA_OE,
    input  logic [7:0] TLCD_DATA_IN,
    output logic [7:0] RD_DATA,
    output logic       RD_VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);
    localparam int PW = $clog2(E_HIGH_CYCLES + E_LOW_CYCLES + 1);
    localparam logic [PW-1:0] PH_HI_LAST = PW'(E_HIGH_CYCLES);
    localparam logic [PW-1:0] PH_END     = PW'(E_HIGH_CYCLES + E_LOW_CYCLES);
    localparam logic [7:0]    POLL_LIMIT = 8'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BF_POLL1 = 3'd1,
        S_SET_ADDR = 3'd2,
        S_BF_POLL2 = 3'd3,
        S_READ     = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] phase_r, phase_s;
    logic [7:0]    poll_cnt_r, poll_cnt_s, poll_inc_s;
    logic [5:0]    remain_r, remain_s;
    logic          sel_r, sel_s, bf_r, bf_s;
    logic [6:0]    addr_r, addr_s;
    logic [7:0]    rd_data_r, rd_data_s, dout_r, dout_s, cmd_s;
    logic          rd_valid_r, rd_valid_s, done_r, done_s, error_r, error_s;
    logic          e_r, e_s, rs_r, rs_s, rw_r, rw_s, oe_r, oe_s, busy_r, busy_s;

    // Next-state, access sequencing and next registered bus/status outputs.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        poll_cnt_s = poll_cnt_r;
        remain_s   = remain_r;
        sel_s      = sel_r;
        addr_s     = addr_r;
        bf_s       = bf_r;
        rd_data_s  = rd_data_r;
        rd_valid_s = 1'b0;
        done_s     = done_r;
        error_s    = error_r;
        poll_inc_s = poll_cnt_r + 8'd1;
        case (state_r)
            S_IDLE: begin
                phase_s = '0;
                if (START) begin
                    sel_s      = SEL_CGRAM;
                    addr_s     = ADDR;
                    remain_s   = LEN;
                    poll_cnt_s = 8'd0;
                    done_s     = 1'b0;
                    error_s    = 1'b0;
                    state_s    = S_BF_POLL1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BF_POLL1, S_BF_POLL2, S_SET_ADDR, S_READ: begin
                phase_s = (phase_r == PH_END) ? '0 : phase_r + PW'(1);
                // Bus data is captured on the last E-high cycle; the byte strobe lands right after E falls.
                if (phase_r == PH_HI_LAST) begin
                    if (state_r == S_READ) begin
                        rd_data_s  = TLCD_DATA_IN;
                        rd_valid_s = 1'b1;
                        remain_s   = remain_r - 6'd1;
                    end else begin
                        bf_s = TLCD_DATA_IN[7];
                    end
                end else begin
                    bf_s = bf_r;
                end
                if (phase_r == PH_END) begin
                    case (state_r)
                        S_BF_POLL1, S_BF_POLL2: begin
                            if (bf_r) begin
                                poll_cnt_s = poll_inc_s;
                                if (poll_inc_s == POLL_LIMIT) begin
                                    state_s = S_IDLE;
                                    error_s = 1'b1;
                                    done_s  = 1'b1;
                                end else begin
                                    state_s = state_r;
                                end
                            end else begin
                                poll_cnt_s = 8'd0;
                                if (state_r == S_BF_POLL1) begin
                                    state_s = S_SET_ADDR;
                                end else if (remain_r == 6'd0) begin
                                    state_s = S_IDLE;
                                    done_s  = 1'b1;
                                end else begin
                                    state_s = S_READ;
                                end
                            end
                        end
                        S_SET_ADDR: state_s = S_BF_POLL2;
                        S_READ: begin
                            if (remain_r == 6'd0) begin
                                state_s = S_IDLE;
                                done_s  = 1'b1;
                            end else begin
                                state_s = S_READ;
                            end
                        end
                        default: state_s = S_IDLE;
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = S_IDLE;
                phase_s = '0;
            end
        endcase

        cmd_s  = sel_s ? {2'b01, addr_s[5:0]} : {1'b1, addr_s};
        busy_s = (state_s != S_IDLE);
        e_s    = busy_s && (phase_s != '0) && (phase_s <= PH_HI_LAST);
        rs_s   = (state_s == S_READ);
        rw_s   = (state_s != S_SET_ADDR);
        oe_s   = (state_s == S_SET_ADDR);
        dout_s = oe_s ? cmd_s : 8'h00;
    end

    // State and output registers; reset drops E at once and discards any byte in flight.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state_r    <= S_IDLE;
            phase_r    <= '0;
            poll_cnt_r <= 8'd0;
            remain_r   <= 6'd0;
            sel_r      <= 1'b0;
            addr_r     <= 7'd0;
            bf_r       <= 1'b0;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            e_r        <= 1'b0;
            rs_r       <= 1'b0;
            rw_r       <= 1'b1;
            oe_r       <= 1'b0;
            dout_r     <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            poll_cnt_r <= poll_cnt_s;
            remain_r   <= remain_s;
            sel_r      <= sel_s;
            addr_r     <= addr_s;
            bf_r       <= bf_s;
            rd_data_r  <= rd_data_s;
            rd_valid_r <= rd_valid_s;
            done_r     <= done_s;
            error_r    <= error_s;
            e_r        <= e_s;
            rs_r       <= rs_s;
            rw_r       <= rw_s;
            oe_r       <= oe_s;
            dout_r     <= dout_s;
            busy_r     <= busy_s;
        end
    end

    assign TLCD_E        = e_r;
    assign TLCD_RS       = rs_r;
    assign TLCD_RW       = rw_r;
    assign TLCD_DATA_OUT = dout_r;
    assign TLCD_DATA_OE  = oe_r;
    assign RD_DATA       = rd_data_r;
    assign RD_VALID      = rd_valid_r;
    assign BUSY          = busy_r;
    assign DONE          = done_r;
    assign ERROR         = error_r;
endmodule

// File: tb/tb_lcd_ram_reader.sv
// Bench for lcd_ram_reader: an LCD bus model with CGRAM/DDRAM arrays and auto-increment,
// plus directed and randomized requests checked against expectations derived from the arrays.
module tb_lcd_ram_reader;
    localparam int EH = 2, EL = 2, TMO = 4, ACC = 1 + EH + EL;

    logic       CLK = 1'b0, RESETN = 1'b1, START = 1'b0, SEL_CGRAM = 1'b0;
    logic [6:0] ADDR = 7'd0;
    logic [5:0] LEN = 6'd0;
    logic [7:0] TLCD_DATA_IN = 8'h00;
    logic       TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA_OE, RD_VALID, BUSY, DONE, ERROR;
    logic [7:0] TLCD_DATA_OUT, RD_DATA;

    lcd_ram_reader #(.E_HIGH_CYCLES(EH), .E_LOW_CYCLES(EL), .BUSY_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .SEL_CGRAM(SEL_CGRAM), .ADDR(ADDR), .LEN(LEN),
        .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW), .TLCD_DATA_OUT(TLCD_DATA_OUT),
        .TLCD_DATA_OE(TLCD_DATA_OE), .TLCD_DATA_IN(TLCD_DATA_IN), .RD_DATA(RD_DATA),
        .RD_VALID(RD_VALID), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR));

    always #5 CLK = ~CLK;

    int total = 0, bad = 0, cyc = 0;
    logic [7:0] cg [64];
    logic [7:0] dd [128];
    bit   mem_cg = 1'b0;
    int   ptr = 0, busy_per_phase = 0, busy_left = 0;
    int   n_poll = 0, n_wr = 0, n_rd = 0, proto_bad = 0;
    logic [7:0] wr_byte = 8'h00;
    logic wr_oe = 1'b0, acc_rs = 1'b0, acc_rw = 1'b1;
    logic [7:0] rd_q [$];
    int   rd_t [$];

    always @(posedge CLK) cyc++;

    // LCD side: classify each access on E rise and present read data while E is high.
    always @(posedge TLCD_E) begin
        acc_rs = TLCD_RS;
        acc_rw = TLCD_RW;
        if (!TLCD_RW) begin
            n_wr++;
            wr_byte = TLCD_DATA_OUT;
            wr_oe = TLCD_DATA_OE;
            if (wr_byte[7]) begin mem_cg = 1'b0; ptr = int'(wr_byte[6:0]); end
            else if (wr_byte[6]) begin mem_cg = 1'b1; ptr = int'(wr_byte[5:0]); end
        end else if (!TLCD_RS) begin
            n_poll++;
            if (busy_left > 0) begin
                busy_left--;
                TLCD_DATA_IN = 8'h80 | 8'($urandom_range(0, 127));
            end else begin
                busy_left = busy_per_phase;
                TLCD_DATA_IN = 8'($urandom_range(0, 127));
            end
        end else begin
            n_rd++;
            TLCD_DATA_IN = mem_cg ? cg[ptr] : dd[ptr];
            ptr = mem_cg ? (ptr + 1) % 64 : (ptr + 1) % 128;
        end
    end

    // Byte capture and bus-protocol watch.
    always @(negedge CLK) begin
        if (RD_VALID) begin rd_q.push_back(RD_DATA); rd_t.push_back(cyc); end
        if (TLCD_RW && TLCD_DATA_OE) proto_bad++;
        if (TLCD_E && (TLCD_RS !== acc_rs || TLCD_RW !== acc_rw)) proto_bad++;
    end

    // Caller is at a negedge; START is sampled on the following posedge.
    task automatic kick(input bit sel, input logic [6:0] a, input logic [5:0] l, input int bpp);
        busy_per_phase = bpp; busy_left = bpp;
        n_poll = 0; n_wr = 0; n_rd = 0; wr_byte = 8'h00; wr_oe = 1'b0;
        rd_q.delete(); rd_t.delete();
        SEL_CGRAM = sel; ADDR = a; LEN = l; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; SEL_CGRAM = 1'($urandom); ADDR = 7'($urandom); LEN = 6'($urandom);
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (DONE) begin timed_out = 1'b0; break; end
            @(negedge CLK);
        end
    endtask

    task automatic do_request(input bit sel, input logic [6:0] a, input logic [5:0] l, input int bpp,
                              output bit timed_out);
        @(negedge CLK);
        kick(sel, a, l, bpp);
        wait_done(timed_out);
    endtask

    task automatic test_reset();
        logic [23:0] got;
        repeat (3) @(negedge CLK);
        got = {TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA_OE, TLCD_DATA_OUT, RD_DATA, RD_VALID, BUSY, DONE, ERROR};
        total++;
        if (got !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'b0000}) begin
            bad++; $display("FAIL reset_state: got %h want %h", got, {4'b0010, 16'h0000, 4'b0000});
        end
        RESETN = 1'b0;
    endtask

    task automatic test_cgram();
        logic [7:0] glyph [8] = '{8'h06, 8'h07, 8'h04, 8'h06, 8'h0C, 8'h1C, 8'h1C, 8'h14};
        bit to;
        int errs = 0;
        for (int i = 0; i < 8; i++) cg[i] = glyph[i];
        do_request(1'b1, 7'h00, 6'd8, 0, to);
        total++; if (to) begin bad++; $display("FAIL cg_done_wait: got timeout want DONE"); end
        total++; if (n_wr !== 1 || wr_byte !== 8'h40 || wr_oe !== 1'b1) begin
            bad++; $display("FAIL cg_addr: got n=%0d byte=%h oe=%b want n=1 byte=40 oe=1", n_wr, wr_byte, wr_oe); end
        total++; if (rd_q.size() != 8) begin
            bad++; $display("FAIL cg_count: got %0d want 8", rd_q.size()); end
        for (int i = 0; i < rd_q.size() && i < 8; i++) begin
            if (rd_q[i] !== glyph[i]) errs++;
            if (i > 0 && rd_t[i] - rd_t[i-1] != ACC) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL cg_bytes: got %0d errors want 0", errs); end
        total++; if ({DONE, ERROR, BUSY} !== 3'b100 || n_poll != 2) begin
            bad++; $display("FAIL cg_status: got dEb=%b polls=%0d want 100 polls=2", {DONE, ERROR, BUSY}, n_poll); end
    endtask

    task automatic test_busy_poll();
        bit to;
        do_request(1'b0, 7'h45, 6'd3, 3, to);
        total++; if (to || n_poll != 8) begin bad++; $display("FAIL bp_polls: got %0d want 8", n_poll); end
        total++; if (wr_byte !== 8'hC5) begin bad++; $display("FAIL bp_addr: got %h want c5", wr_byte); end
        total++; if (rd_q.size() != 3 || rd_q[0] !== dd[69] || rd_q[1] !== dd[70] || rd_q[2] !== dd[71]) begin
            bad++; $display("FAIL bp_bytes: got n=%0d want 3 bytes %h %h %h", rd_q.size(), dd[69], dd[70], dd[71]); end
        total++; if ({DONE, ERROR} !== 2'b10) begin bad++; $display("FAIL bp_status: got %b want 10", {DONE, ERROR}); end
    endtask

    task automatic test_timeout();
        bit to;
        do_request(1'b1, 7'($urandom), 6'd5, 1000, to);
        total++; if (to || n_poll != TMO) begin bad++; $display("FAIL to_polls: got %0d want %0d", n_poll, TMO); end
        total++; if (n_wr != 0 || n_rd != 0 || rd_q.size() != 0) begin
            bad++; $display("FAIL to_no_access: got wr=%0d rd=%0d valid=%0d want 0 0 0", n_wr, n_rd, rd_q.size()); end
        total++; if ({DONE, ERROR, BUSY} !== 3'b110) begin
            bad++; $display("FAIL to_status: got %b want 110", {DONE, ERROR, BUSY}); end
    endtask

    task automatic test_len_zero();
        bit to;
        @(negedge CLK);
        kick(1'b0, 7'h10, 6'd0, 0);
        repeat (3) @(negedge CLK);
        SEL_CGRAM = 1'b1; ADDR = 7'h22; LEN = 6'd5; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(to);
        repeat (20) @(negedge CLK);
        total++; if (to || wr_byte !== 8'h90 || n_wr != 1) begin
            bad++; $display("FAIL lz_addr: got %h n=%0d want 90 n=1", wr_byte, n_wr); end
        total++; if (n_poll != 2 || n_rd != 0 || rd_q.size() != 0 || BUSY !== 1'b0) begin
            bad++; $display("FAIL lz_counts: got polls=%0d rd=%0d valid=%0d want 2 0 0", n_poll, n_rd, rd_q.size()); end
        total++; if ({DONE, ERROR} !== 2'b10) begin bad++; $display("FAIL lz_status: got %b want 10", {DONE, ERROR}); end
    endtask

    task automatic test_back_to_back();
        bit to;
        do_request(1'b0, 7'h01, 6'd2, TMO, to);
        total++; if (to || ERROR !== 1'b1) begin bad++; $display("FAIL b2b_first: got err=%b want 1", ERROR); end
        kick(1'b1, 7'h3E, 6'd4, 1);
        total++; if ({DONE, ERROR, BUSY} !== 3'b001) begin
            bad++; $display("FAIL b2b_clear: got %b want 001", {DONE, ERROR, BUSY}); end
        wait_done(to);
        total++; if (to || rd_q.size() != 4 || rd_q[0] !== cg[62] || rd_q[3] !== cg[1] || ERROR !== 1'b0) begin
            bad++; $display("FAIL b2b_second: got n=%0d want 4 bytes from cg[62] wrapping", rd_q.size()); end
        total++; if (proto_bad != 0) begin bad++; $display("FAIL protocol: got %0d violations want 0", proto_bad); end
    endtask

    task automatic test_reset_mid_read();
        bit hit = 1'b0, to;
        int prior;
        @(negedge CLK);
        kick(1'b1, 7'h00, 6'd20, 0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (n_rd >= 2 && TLCD_E && TLCD_RS) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("FAIL rst_reach_read: got timeout want E high in read"); end
        prior = rd_q.size();
        RESETN = 1'b1;
        #1;
        total++; if ({TLCD_E, BUSY, TLCD_RW, TLCD_DATA_OE, RD_VALID} !== 5'b00100) begin
            bad++; $display("FAIL rst_async: got %b want 00100", {TLCD_E, BUSY, TLCD_RW, TLCD_DATA_OE, RD_VALID}); end
        repeat (2) @(negedge CLK);
        RESETN = 1'b0;
        repeat (10) @(negedge CLK);
        total++; if (rd_q.size() != prior || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++; $display("FAIL rst_quiet: got valid=%0d busy=%b want %0d 0", rd_q.size(), BUSY, prior); end
        do_request(1'b1, 7'h08, 6'd4, 1, to);
        total++; if (to || rd_q.size() != 4 || rd_q[0] !== cg[8] || rd_q[3] !== cg[11]) begin
            bad++; $display("FAIL rst_recover: got n=%0d want 4", rd_q.size()); end
    endtask

    task automatic test_random();
        bit to, sel;
        logic [6:0] a;
        logic [5:0] l;
        logic [7:0] exp_cmd, exp_b;
        int bpp, errs, exp_polls, exp_n;
        for (int it = 0; it < 12; it++) begin
            sel = 1'($urandom); a = 7'($urandom); l = 6'($urandom_range(0, 20)); bpp = $urandom_range(0, 5);
            do_request(sel, a, l, bpp, to);
            errs = 0;
            if (bpp >= TMO) begin exp_polls = TMO; exp_n = 0; end
            else begin exp_polls = 2 * (bpp + 1); exp_n = int'(l); end
            exp_cmd = sel ? (8'h40 | {2'b00, a[5:0]}) : (8'h80 | {1'b0, a});
            if (bpp < TMO && (n_wr != 1 || wr_byte !== exp_cmd)) errs++;
            if (bpp >= TMO && n_wr != 0) errs++;
            if (n_poll != exp_polls || rd_q.size() != exp_n) errs++;
            if ({DONE, ERROR} !== {1'b1, bpp >= TMO}) errs++;
            for (int i = 0; i < rd_q.size() && i < exp_n; i++) begin
                exp_b = sel ? cg[(int'(a[5:0]) + i) % 64] : dd[(int'(a) + i) % 128];
                if (rd_q[i] !== exp_b) errs++;
            end
            total++;
            if (to || errs != 0) begin
                bad++;
                $display("FAIL rand_req%0d: got %0d errors polls=%0d valid=%0d want 0 polls=%0d valid=%0d",
                         it, errs, n_poll, rd_q.size(), exp_polls, exp_n);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) cg[i] = 8'($urandom);
        for (int i = 0; i < 128; i++) dd[i] = 8'($urandom);
        test_reset();
        test_reset_mid_read();
        test_cgram();
        test_busy_poll();
        test_timeout();
        test_len_zero();
        test_back_to_back();
        test_random();
        total++; if (proto_bad != 0) begin bad++; $display("FAIL protocol_final: got %0d want 0", proto_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
